// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values and the instruction fetch state encoding.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_HI = 2'd1,
        ST_RD_LO = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    // True while the fetch FSM is strobing program memory for a byte.
    function automatic logic is_read_state(input fetch_state_t s);
        return (s == ST_RD_HI) || (s == ST_RD_LO);
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Per-byte memory wait counter; flags expiry once WAIT_MAX wait cycles have elapsed.
module fetch_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count_r;

    // Counter saturates at WAIT_MAX so an unconsumed expiry cannot wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && !expired) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/instruction_fetch_register.sv
// Two-byte instruction fetch from 8-bit program memory, with PC increment pulses,
// a held instruction register and opcode decode for the controller and PC.
module instruction_fetch_register #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 13,
    parameter int WAIT_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_req,
    output logic                       mem_rd,
    input  logic                       mem_rdy,
    input  logic [DATA_W-1:0]          mem_data,
    output logic                       inc_pc,
    output logic                       ir_valid,
    input  logic                       ir_ack,
    output logic [2*DATA_W-ADDR_W-1:0] opcode,
    output logic [ADDR_W-1:0]          ir_addr,
    output logic                       is_jmp,
    output logic                       is_hlt,
    output logic                       fetch_err
);

    import cpu_pkg::*;

    localparam int IR_W = 2 * DATA_W;
    localparam int OP_W = IR_W - ADDR_W;

    fetch_state_t      state_r;
    logic [IR_W-1:0]   ir_r;
    logic              rd_state_s;
    logic              capture_s;
    logic              timeout_s;
    logic              holding_s;
    logic              timer_clear_s;
    logic              timer_en_s;
    logic              expired_s;
    logic [OP_W-1:0]   opcode_s;

    // Datapath qualifiers shared by the FSM, the wait timer and the Mealy outputs.
    always_comb begin
        rd_state_s    = is_read_state(state_r);
        capture_s     = rd_state_s && mem_rdy;
        timeout_s     = rd_state_s && !mem_rdy && expired_s;
        holding_s     = (state_r == ST_HOLD);
        timer_clear_s = !rd_state_s || mem_rdy;
        timer_en_s    = rd_state_s && !mem_rdy;
    end

    fetch_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear_s),
        .enable  (timer_en_s),
        .expired (expired_s)
    );

    // Fetch FSM and instruction register; data wins over timeout in the expiry cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ir_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fetch_req) begin
                        state_r <= ST_RD_HI;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RD_HI: begin
                    if (mem_rdy) begin
                        ir_r[IR_W-1:DATA_W] <= mem_data;
                        state_r             <= ST_RD_LO;
                    end else if (expired_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RD_HI;
                    end
                end
                ST_RD_LO: begin
                    if (mem_rdy) begin
                        ir_r[DATA_W-1:0] <= mem_data;
                        state_r          <= ST_HOLD;
                    end else if (expired_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RD_LO;
                    end
                end
                ST_HOLD: begin
                    if (ir_ack) begin
                        state_r <= fetch_req ? ST_RD_HI : ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        opcode_s  = rst ? '0 : ir_r[IR_W-1:ADDR_W];
        opcode    = opcode_s;
        ir_addr   = rst ? '0 : ir_r[ADDR_W-1:0];
        mem_rd    = !rst && rd_state_s;
        inc_pc    = !rst && capture_s;
        fetch_err = !rst && timeout_s;
        ir_valid  = !rst && holding_s;
        is_jmp    = !rst && holding_s && (opcode_s == OP_W'(OP_JMP));
        is_hlt    = !rst && holding_s && (opcode_s == OP_W'(OP_HLT));
    end

endmodule

// File: tb/tb_instruction_fetch_register.sv
// Randomised self-checking bench for instruction_fetch_register with a
// memory/PC model and a cycle-count reference for fetch timing.
module tb_instruction_fetch_register;

    localparam int WAIT_MAX = 15;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        mem_rd;
    logic        mem_rdy;
    logic [7:0]  mem_data;
    logic        inc_pc;
    logic        ir_valid;
    logic        ir_ack;
    logic [2:0]  opcode;
    logic [12:0] ir_addr;
    logic        is_jmp;
    logic        is_hlt;
    logic        fetch_err;

    int checks;
    int failures;

    logic [7:0] mem [256];
    int pc;

    int r_inc, r_rd, r_err, r_err_c, r_valid_c, r_first_rd, r_last_rd;

    instruction_fetch_register #(
        .DATA_W   (8),
        .ADDR_W   (13),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (fetch_req),
        .mem_rd    (mem_rd),
        .mem_rdy   (mem_rdy),
        .mem_data  (mem_data),
        .inc_pc    (inc_pc),
        .ir_valid  (ir_valid),
        .ir_ack    (ir_ack),
        .opcode    (opcode),
        .ir_addr   (ir_addr),
        .is_jmp    (is_jmp),
        .is_hlt    (is_hlt),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: cycle of ir_valid / fetch_err, inc_pc count and mem_rd cycles,
    // counted from the cycle fetch_req is sampled (cycle 0).
    function automatic void model_fetch(input int w_hi, input int w_lo,
                                        output int e_valid, output int e_err,
                                        output int e_inc, output int e_rd);
        if (w_hi > WAIT_MAX) begin
            e_valid = -1; e_err = WAIT_MAX + 1; e_inc = 0; e_rd = WAIT_MAX + 1;
        end else if (w_lo > WAIT_MAX) begin
            e_valid = -1; e_err = w_hi + 1 + WAIT_MAX + 1; e_inc = 1; e_rd = e_err;
        end else begin
            e_valid = w_hi + w_lo + 3; e_err = -1; e_inc = 2; e_rd = w_hi + w_lo + 2;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drives one fetch with the memory answering after w_hi / w_lo wait cycles.
    task automatic run_fetch(input int w_hi, input int w_lo, input logic ack0);
        int byte_i;
        int waited;
        byte_i = 0; waited = 0;
        r_inc = 0; r_rd = 0; r_err = 0; r_err_c = -1; r_valid_c = -1;
        r_first_rd = -1; r_last_rd = -1;
        for (int c = 0; c < 60; c++) begin
            fetch_req = (c == 0);
            ir_ack    = (c == 0) ? ack0 : 1'b0;
            mem_rdy   = 1'b0;
            mem_data  = 8'($urandom);
            #1;
            if (mem_rd && (waited == ((byte_i == 0) ? w_hi : w_lo))) begin
                mem_rdy  = 1'b1;
                mem_data = mem[pc & 255];
            end
            #1;
            if (mem_rd) begin
                r_rd++;
                if (r_first_rd < 0) r_first_rd = c;
                r_last_rd = c;
            end
            if (inc_pc) begin
                r_inc++; pc++; byte_i++; waited = 0;
            end else if (mem_rd) begin
                waited++;
            end
            if (fetch_err) begin
                r_err++; r_err_c = c;
            end
            if (c > 0 && ir_valid && r_valid_c < 0) r_valid_c = c;
            tick();
            if (r_valid_c >= 0 || r_err_c >= 0) break;
        end
        fetch_req = 1'b0; ir_ack = 1'b0; mem_rdy = 1'b0;
        #1;
    endtask

    task automatic release_ir();
        ir_ack = 1'b1; fetch_req = 1'b0;
        tick();
        ir_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b1; mem_rdy = 1'b1; ir_ack = 1'b0; mem_data = 8'hFF;
        #2;
        checks++; if ({mem_rd, inc_pc, ir_valid, is_jmp, is_hlt, fetch_err} !== 6'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=000000", {mem_rd, inc_pc, ir_valid, is_jmp, is_hlt, fetch_err}); end
        tick(); tick();
        rst = 1'b0; fetch_req = 1'b0; mem_rdy = 1'b0;
        #2;
        checks++; if ({mem_rd, ir_valid, opcode, ir_addr} !== 18'b0) begin failures++; $display("FAIL reset_state got=%h exp=0", {mem_rd, ir_valid, opcode, ir_addr}); end
        tick();
    endtask

    task automatic test_zero_wait();
        mem[pc & 255] = 8'hE0; mem[(pc + 1) & 255] = 8'h05;
        run_fetch(0, 0, 1'b0);
        checks++; if (r_valid_c !== 3) begin failures++; $display("FAIL zw_valid_cycle got=%0d exp=3", r_valid_c); end
        checks++; if (r_inc !== 2) begin failures++; $display("FAIL zw_inc_count got=%0d exp=2", r_inc); end
        checks++; if (r_first_rd !== 1 || r_last_rd !== 2 || r_rd !== 2) begin failures++; $display("FAIL zw_mem_rd got=%0d..%0d n=%0d exp=1..2 n=2", r_first_rd, r_last_rd, r_rd); end
        checks++; if (opcode !== 3'd7 || ir_addr !== 13'h0005) begin failures++; $display("FAIL zw_decode got=%h/%h exp=7/0005", opcode, ir_addr); end
        checks++; if (is_jmp !== 1'b1 || is_hlt !== 1'b0) begin failures++; $display("FAIL zw_is_jmp got=%b%b exp=10", is_jmp, is_hlt); end
        release_ir();
    endtask

    task automatic test_delayed();
        mem[pc & 255] = 8'hA1; mem[(pc + 1) & 255] = 8'h23;
        run_fetch(3, 3, 1'b0);
        checks++; if (r_valid_c !== 9) begin failures++; $display("FAIL dly_valid_cycle got=%0d exp=9", r_valid_c); end
        checks++; if (r_inc !== 2) begin failures++; $display("FAIL dly_inc_count got=%0d exp=2", r_inc); end
        checks++; if (r_first_rd !== 1 || r_last_rd !== 8 || r_rd !== 8) begin failures++; $display("FAIL dly_mem_rd got=%0d..%0d n=%0d exp=1..8 n=8", r_first_rd, r_last_rd, r_rd); end
        checks++; if (opcode !== 3'd5 || ir_addr !== 13'h0123 || is_jmp !== 1'b0) begin failures++; $display("FAIL dly_decode got=%h/%h/%b exp=5/0123/0", opcode, ir_addr, is_jmp); end
        release_ir();
    endtask

    task automatic test_timeout();
        run_fetch(100, 0, 1'b0);
        checks++; if (r_err_c !== 16 || r_err !== 1) begin failures++; $display("FAIL to_err_cycle got=%0d n=%0d exp=16 n=1", r_err_c, r_err); end
        checks++; if (r_inc !== 0 || r_valid_c !== -1) begin failures++; $display("FAIL to_no_inc got=%0d/%0d exp=0/-1", r_inc, r_valid_c); end
        checks++; if (mem_rd !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL to_idle got=%b%b exp=00", mem_rd, ir_valid); end
        mem[pc & 255] = 8'h4C; mem[(pc + 1) & 255] = 8'h9E;
        run_fetch(15, 0, 1'b0);
        checks++; if (r_err !== 0 || r_valid_c !== 18 || r_inc !== 2) begin failures++; $display("FAIL late_rdy got=err%0d/v%0d/i%0d exp=err0/v18/i2", r_err, r_valid_c, r_inc); end
        checks++; if (opcode !== 3'd2 || ir_addr !== 13'h0C9E) begin failures++; $display("FAIL late_decode got=%h/%h exp=2/0c9e", opcode, ir_addr); end
        release_ir();
    endtask

    task automatic test_back_to_back();
        mem[pc & 255] = 8'h7F; mem[(pc + 1) & 255] = 8'h10;
        run_fetch(0, 1, 1'b0);
        mem[pc & 255] = 8'h00; mem[(pc + 1) & 255] = 8'h00;
        run_fetch(0, 0, 1'b1);
        checks++; if (r_first_rd !== 1 || r_valid_c !== 3) begin failures++; $display("FAIL b2b_timing got=rd%0d/v%0d exp=rd1/v3", r_first_rd, r_valid_c); end
        checks++; if (is_hlt !== 1'b1 || opcode !== 3'd0 || ir_addr !== 13'h0) begin failures++; $display("FAIL b2b_hlt got=%b/%h/%h exp=1/0/0", is_hlt, opcode, ir_addr); end
        release_ir();
    endtask

    task automatic test_reset_in_rd_lo();
        mem[pc & 255] = 8'hD5; mem[(pc + 1) & 255] = 8'h5A;
        fetch_req = 1'b1; #2; tick();
        fetch_req = 1'b0; mem_rdy = 1'b1; mem_data = mem[pc & 255]; #2;
        if (inc_pc) pc++;
        tick();
        rst = 1'b1; mem_rdy = 1'b1; mem_data = mem[pc & 255]; #2;
        checks++; if (inc_pc !== 1'b0 || fetch_err !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL rst_rdlo_pulse got=%b%b%b exp=000", inc_pc, fetch_err, mem_rd); end
        if (inc_pc) pc++;
        tick();
        rst = 1'b0; mem_rdy = 1'b0; #2;
        checks++; if (ir_valid !== 1'b0 || opcode !== 3'd0 || ir_addr !== 13'h0 || mem_rd !== 1'b0) begin failures++; $display("FAIL rst_rdlo_after got=%b/%h/%h/%b exp=0/0/0/0", ir_valid, opcode, ir_addr, mem_rd); end
        tick();
    endtask

    task automatic test_ignored_inputs();
        logic [15:0] exp_ir;
        ir_ack = 1'b1; mem_rdy = 1'b1; fetch_req = 1'b0; #2;
        checks++; if (inc_pc !== 1'b0) begin failures++; $display("FAIL idle_ack_inc got=%b exp=0", inc_pc); end
        tick();
        ir_ack = 1'b0; mem_rdy = 1'b0; #2;
        checks++; if (mem_rd !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL idle_ack_state got=%b%b exp=00", mem_rd, ir_valid); end
        tick();
        mem[pc & 255] = 8'($urandom); mem[(pc + 1) & 255] = 8'($urandom);
        exp_ir = {mem[pc & 255], mem[(pc + 1) & 255]};
        run_fetch(1, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            mem_rdy = 1'b1; mem_data = ~exp_ir[7:0]; #2;
            checks++; if (inc_pc !== 1'b0) begin failures++; $display("FAIL hold_rdy_inc got=%b exp=0", inc_pc); end
            tick();
        end
        mem_rdy = 1'b0; #1;
        checks++; if (ir_valid !== 1'b1 || {opcode, ir_addr} !== exp_ir) begin failures++; $display("FAIL hold_frozen got=%b/%h exp=1/%h", ir_valid, {opcode, ir_addr}, exp_ir); end
        release_ir();
    endtask

    task automatic test_random();
        int w_hi, w_lo, sel, pc0;
        int e_valid, e_err, e_inc, e_rd;
        logic [15:0] exp_ir;
        for (int n = 0; n < 24; n++) begin
            w_hi = $urandom_range(0, 4); w_lo = $urandom_range(0, 4);
            sel = $urandom_range(0, 9);
            if (sel == 0) w_hi = $urandom_range(16, 20);
            if (sel == 1) w_lo = $urandom_range(16, 20);
            if (sel == 2) w_lo = 15;
            pc0 = pc;
            mem[pc0 & 255] = 8'($urandom); mem[(pc0 + 1) & 255] = 8'($urandom);
            exp_ir = {mem[pc0 & 255], mem[(pc0 + 1) & 255]};
            model_fetch(w_hi, w_lo, e_valid, e_err, e_inc, e_rd);
            run_fetch(w_hi, w_lo, 1'b0);
            checks++; if (r_valid_c !== e_valid || r_err_c !== e_err) begin failures++; $display("FAIL rnd_timing w=%0d/%0d got=v%0d/e%0d exp=v%0d/e%0d", w_hi, w_lo, r_valid_c, r_err_c, e_valid, e_err); end
            checks++; if (r_inc !== e_inc || r_rd !== e_rd) begin failures++; $display("FAIL rnd_counts w=%0d/%0d got=i%0d/r%0d exp=i%0d/r%0d", w_hi, w_lo, r_inc, r_rd, e_inc, e_rd); end
            if (e_valid >= 0) begin
                checks++; if ({opcode, ir_addr} !== exp_ir || is_jmp !== (exp_ir[15:13] == 3'd7) || is_hlt !== (exp_ir[15:13] == 3'd0)) begin failures++; $display("FAIL rnd_decode got=%h/%b%b exp=%h", {opcode, ir_addr}, is_jmp, is_hlt, exp_ir); end
                release_ir();
            end else begin
                checks++; if (mem_rd !== 1'b0 || ir_valid !== 1'b0) begin failures++; $display("FAIL rnd_to_idle got=%b%b exp=00", mem_rd, ir_valid); end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; pc = 0;
        rst = 1'b1; fetch_req = 1'b0; mem_rdy = 1'b0; mem_data = 8'h00; ir_ack = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_delayed();
        test_timeout();
        test_back_to_back();
        test_reset_in_rd_lo();
        test_ignored_inputs();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_register.md
# instruction_fetch_register

Fetches one 16-bit instruction from the 8-bit program memory as two bytes (high byte first) at the address driven by the program counter, pulses the PC increment after each byte, and holds the assembled instruction for the controller. Sits between program memory/program counter and the machine controller. It supplies the jump target and jump decode that the PC uses when it loads a new address.

## Interface
- DATA_W, 8: program memory data width; the instruction is 2*DATA_W bits.
- ADDR_W, 13: operand/jump-address width; the opcode width is 2*DATA_W-ADDR_W (3).
- WAIT_MAX, 15: maximum cycles to wait for mem_rdy per byte before aborting.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  controller requests an instruction fetch; level, sampled in IDLE and HOLD.
- mem_rd  out  1  program memory read strobe; the address is the current PC value.
- mem_rdy  in  1  mem_data is valid this cycle.
- mem_data  in  DATA_W  program memory read data.
- inc_pc  out  1  one-cycle pulse; advances the PC after a byte is captured.
- ir_valid  out  1  assembled instruction held and valid.
- ir_ack  in  1  consumer has taken the instruction.
- opcode  out  3  instruction bits [15:13].
- ir_addr  out  ADDR_W  instruction bits [12:0]; operand address or jump target.
- is_jmp  out  1  ir_valid and opcode==JMP (3'b111); drives the PC's load_pc path.
- is_hlt  out  1  ir_valid and opcode==HLT (3'b000).
- fetch_err  out  1  one-cycle pulse on a memory wait timeout.

## Operation
- The FSM has four states: IDLE, RD_HI, RD_LO, HOLD. Reset state is IDLE.
- IDLE: if fetch_req is high, go to RD_HI. mem_rdy and ir_ack are ignored.
- RD_HI: mem_rd=1.
  - If mem_rdy: ir[15:8]<=mem_data, inc_pc=1, go to RD_LO.
  - Otherwise the wait counter increments.
- RD_LO: mem_rd=1.
  - If mem_rdy: ir[7:0]<=mem_data, inc_pc=1, go to HOLD.
  - Otherwise the wait counter increments.
- Wait counter: width clog2(WAIT_MAX+1). It clears on entry to RD_HI or RD_LO and on each capture.
  - Timeout condition: count==WAIT_MAX and mem_rdy is low.
  - On timeout: fetch_err=1, no capture, no inc_pc, go to IDLE. ir_valid stays 0.
  - If mem_rdy is high in the same cycle as count==WAIT_MAX, the data is captured and no error is raised.
- HOLD: ir_valid=1 and ir is frozen.
  - On ir_ack with fetch_req high: go directly to RD_HI (back-to-back fetch, no IDLE cycle).
  - On ir_ack with fetch_req low: go to IDLE.
- fetch_req is ignored outside IDLE and HOLD. mem_rdy is ignored outside RD_HI and RD_LO.
- opcode and ir_addr always reflect the ir register. Their contents are only meaningful while ir_valid is high. The high byte is overwritten during RD_HI.
- inc_pc and fetch_err are Mealy outputs, combinational from state, mem_rdy, counter and rst.
- mem_rd and ir_valid are decoded from state.
- All outputs are gated by !rst.

## Timing
- Reset values: state IDLE, ir=0, counter=0. mem_rd, inc_pc, ir_valid, is_jmp, is_hlt and fetch_err are all 0.
- Reset during any state (including RD_LO with mem_rdy high):
  - inc_pc and fetch_err are suppressed that cycle.
  - On the next cycle the block is in IDLE with ir=0.
- Zero-wait memory: fetch_req sampled in cycle 0.
  - mem_rd in cycles 1-2.
  - inc_pc in cycles 1 and 2.
  - ir_valid from cycle 3.
- Each wait cycle per byte adds one cycle to the fetch.
- The PC increments on the same edge that captures a byte, so the low byte is read from PC+1 in the next cycle.
- Exactly two inc_pc pulses occur per successful fetch. A timeout in RD_LO leaves the PC advanced by one.

## Structure
- Shared package cpu_pkg holds:
  - Opcode localparams OP_HLT=0, OP_SKZ=1, OP_ADD=2, OP_AND=3, OP_XOR=4, OP_LDA=5, OP_STO=6, OP_JMP=7.
  - The fetch-state encoding.
- One sub-module is natural: fetch_wait_timer (clear, enable, WAIT_MAX parameter → expired flag).
- The FSM, ir register and decode stay in the top-level block.

## Test plan
- Reset, then fetch_req=1 with zero-wait memory returning 0xE0 then 0x05 → ir_valid in cycle 3, opcode=7, ir_addr=0x0005, is_jmp=1, two inc_pc pulses (cycles 1 and 2).
- mem_rdy delayed 3 cycles for each byte, data 0xA1, 0x23 → ir_valid in cycle 9, opcode=5, ir_addr=0x0123, exactly two inc_pc pulses, mem_rd high throughout cycles 1-8.
- mem_rdy never asserted → fetch_err pulses in the 16th RD_HI cycle, IDLE next cycle, zero inc_pc pulses, ir_valid=0.
  - Repeat with mem_rdy first asserted in the 16th RD_HI cycle → data captured, no fetch_err.
- Back-to-back fetches: in HOLD, ir_ack=1 and fetch_req=1 in the same cycle → RD_HI next cycle, ir_valid=0. Second instruction 0x00 0x00 → is_hlt=1.
- Reset asserted in RD_LO while mem_rdy=1 → no inc_pc that cycle. Next cycle: state IDLE, ir_valid=0, opcode=0, ir_addr=0.
- ir_ack pulsed in IDLE and mem_rdy pulsed in HOLD → no state change, no inc_pc, held instruction unchanged.
